// File: rtl/pow_5_pkg.sv
// Shared definitions for the fifth-power pipeline: window FSM encoding and the
// default widths used by the power stage, the window accumulator and the bench.
package pow_5_pkg;

    localparam int DEF_WIDTH     = 18;
    localparam int DEF_LEN       = 8;
    localparam int DEF_SUM_WIDTH = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } win_state_e;

    // Width of a counter that indexes 0..len-1; never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len > 2) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/pow_5_sat_add.sv
// Unsigned saturating adder: clamps to all ones on carry out and reports it.
module pow_5_sat_add #(
    parameter int SUM_WIDTH = 24
) (
    input  logic [SUM_WIDTH-1:0] a_i,
    input  logic [SUM_WIDTH-1:0] b_i,
    output logic [SUM_WIDTH-1:0] sum_o,
    output logic                 ovf_o
);

    logic [SUM_WIDTH:0] raw_sum;

    assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o   = raw_sum[SUM_WIDTH];
    assign sum_o   = ovf_o ? {SUM_WIDTH{1'b1}} : raw_sum[SUM_WIDTH-1:0];

endmodule

// File: rtl/pow_5_window_accumulator.sv
// Sums fixed-length windows of n^5 samples with saturation, tracks the window
// maximum and flags samples lost while a finished window waits for its reader.
module pow_5_window_accumulator
    import pow_5_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LEN       = DEF_LEN,
    parameter int SUM_WIDTH = DEF_SUM_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0]     out_max,
    output logic                 out_overflow,
    output logic                 out_dropped
);

    localparam int                CNT_W    = cnt_width(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    win_state_e           state_q, state_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0]     max_q, max_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 drop_q, drop_d;

    logic [SUM_WIDTH-1:0] sample_ext;
    logic [SUM_WIDTH-1:0] add_sum;
    logic                 add_ovf;

    assign sample_ext = SUM_WIDTH'(in_data);

    pow_5_sat_add #(
        .SUM_WIDTH(SUM_WIDTH)
    ) u_sat_add (
        .a_i  (sum_q),
        .b_i  (sample_ext),
        .sum_o(add_sum),
        .ovf_o(add_ovf)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    sum_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    if (in_data > max_q) begin
                        max_d = in_data;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (in_valid) begin
                    drop_d = 1'b1;
                end
                // A sample offered on the release edge is still lost, so it
                // marks the next window as having dropped data.
                if (out_ready) begin
                    state_d = ACCUM;
                    sum_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    drop_d  = in_valid;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_sum      = sum_q;
    assign out_max      = max_q;
    assign out_overflow = ovf_q;
    assign out_dropped  = drop_q;

endmodule

// File: tb/tb_pow_5_window_accumulator.sv
// Bench for pow_5_window_accumulator: a 24-bit and an 18-bit sum instance share
// one stimulus stream and are compared against a window-level reference model.
module tb_pow_5_window_accumulator;
    import pow_5_pkg::*;

    localparam int W   = DEF_WIDTH;
    localparam int L   = DEF_LEN;
    localparam int SW  = DEF_SUM_WIDTH;
    localparam int SW2 = 18;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;

    logic          in_ready_a, out_valid_a, ovf_a, drop_a;
    logic [SW-1:0] sum_a;
    logic [W-1:0]  max_a;
    logic          in_ready_b, out_valid_b, ovf_b, drop_b;
    logic [SW2-1:0] sum_b;
    logic [W-1:0]  max_b;

    pow_5_window_accumulator #(.WIDTH(W), .LEN(L), .SUM_WIDTH(SW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_max(max_a), .out_overflow(ovf_a), .out_dropped(drop_a)
    );

    pow_5_window_accumulator #(.WIDTH(W), .LEN(L), .SUM_WIDTH(SW2)) dut18 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_max(max_b), .out_overflow(ovf_b), .out_dropped(drop_b)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the current window as a list of accepted samples.
    int unsigned win_q[$];
    bit          m_hold;
    bit          m_drop;

    typedef struct {
        logic        v;
        logic [W-1:0] d;
        logic        r;
        logic        ev;
        longint      es;
        longint      em;
        logic        eo;
        logic        ed;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint m_total();
        longint t = 0;
        foreach (win_q[i]) t += win_q[i];
        return t;
    endfunction

    function automatic longint m_max();
        longint m = 0;
        foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
        return m;
    endfunction

    task automatic model_edge();
        if (reset) begin
            win_q.delete();
            m_hold = 0;
            m_drop = 0;
        end else if (!m_hold) begin
            if (in_valid) win_q.push_back(int'(in_data));
            if (win_q.size() == L) m_hold = 1;
        end else begin
            if (in_valid) m_drop = 1;
            if (out_ready) begin
                m_hold = 0;
                win_q.delete();
                m_drop = in_valid;
            end
        end
    endtask

    task automatic model_check();
        longint lim_a = (longint'(1) << SW) - 1;
        longint lim_b = (longint'(1) << SW2) - 1;
        longint tot   = m_total();
        check("in_ready", in_ready_a, !m_hold);
        check("out_valid", out_valid_a, m_hold);
        check("in_ready18", in_ready_b, !m_hold);
        check("out_valid18", out_valid_b, m_hold);
        if (m_hold) begin
            check("sum", sum_a, (tot > lim_a) ? lim_a : tot);
            check("ovf", ovf_a, tot > lim_a);
            check("max", max_a, m_max());
            check("dropped", drop_a, m_drop);
            check("sum18", sum_b, (tot > lim_b) ? lim_b : tot);
            check("ovf18", ovf_b, tot > lim_b);
            check("max18", max_b, m_max());
            check("dropped18", drop_b, m_drop);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic drive(input logic v, input int unsigned d, input logic r);
        in_valid  = v;
        in_data   = W'(d);
        out_ready = r;
    endtask

    initial begin
        int seen;
        logic [SW-1:0] held_sum;
        logic [W-1:0]  held_max;

        reset = 1'b1;
        drive(0, 0, 0);
        m_hold = 0;
        m_drop = 0;
        #1;
        check("rst_in_ready", in_ready_a, 1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_sum", sum_a, 0);
        check("rst_max", max_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_drop", drop_a, 0);
        step();
        reset = 1'b0;
        step();

        // Window of n^5 for n = 0..7, continuous input, reader always ready.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, W'(i * i * i * i * i), 1'b1, (i == 7), 29008, 16807, 1'b0, 1'b0};
        tbl[8] = '{1'b0, '0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            step();
            check("t1_valid", out_valid_a, tbl[i].ev);
            if (tbl[i].ev) begin
                check("t1_sum", sum_a, tbl[i].es);
                check("t1_max", max_a, tbl[i].em);
                check("t1_ovf", ovf_a, tbl[i].eo);
                check("t1_drop", drop_a, tbl[i].ed);
            end
        end

        // Saturation on the 18-bit instance, then a clean window after it.
        for (int i = 0; i < 8; i++) begin
            drive(1, 200000, 1);
            step();
        end
        check("sat_sum18", sum_b, 262143);
        check("sat_ovf18", ovf_b, 1);
        check("sat_sum24", sum_a, 1600000);
        drive(0, 0, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1);
            step();
        end
        check("post_sat_sum18", sum_b, 8);
        check("post_sat_ovf18", ovf_b, 0);
        drive(0, 0, 1);
        step();

        // Reader stalls for 5 cycles while upstream keeps pushing.
        for (int i = 0; i < 8; i++) begin
            drive(1, $urandom_range(0, 1000), 0);
            step();
        end
        check("stall_valid", out_valid_a, 1);
        held_sum = sum_a;
        held_max = max_a;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_in_ready", in_ready_a, 0);
            check("stall_sum_stable", sum_a, held_sum);
            check("stall_max_stable", max_a, held_max);
        end
        drive(1, 5, 1);
        step();
        check("release_valid", out_valid_a, 0);
        check("release_in_ready", in_ready_a, 1);
        for (int i = 0; i < 7; i++) begin
            drive(1, 9, 0);
            step();
        end
        check("seven_accepts_valid", out_valid_a, 0);
        step();
        check("eighth_accept_valid", out_valid_a, 1);
        check("carried_drop", drop_a, 1);
        check("carried_sum", sum_a, 72);
        drive(0, 0, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1, 4, 0);
            step();
        end
        drive(0, 0, 0);
        check("clean_drop", drop_a, 0);
        drive(0, 0, 1);
        step();

        // Gapped input: a sample every other cycle.
        seen = -1;
        for (int k = 0; k < 16; k++) begin
            drive((k % 2) == 0, (k / 2) + 1, 1);
            step();
            if (out_valid_a && seen < 0) begin
                seen = k;
                check("gap_sum", sum_a, 36);
                check("gap_max", max_a, 8);
            end
        end
        check("gap_edges", seen, 14);
        drive(0, 0, 1);
        step();

        // Asynchronous reset in the middle of a window.
        for (int i = 0; i < 5; i++) begin
            drive(1, 3, 1);
            step();
        end
        drive(0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_sum", sum_a, 0);
        check("arst_max", max_a, 0);
        check("arst_valid", out_valid_a, 0);
        check("arst_in_ready", in_ready_a, 1);
        check("arst_ovf", ovf_a, 0);
        check("arst_drop", drop_a, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 2, 1);
            step();
        end
        check("after_rst_sum", sum_a, 16);
        check("after_rst_valid", out_valid_a, 1);
        drive(0, 0, 1);
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, (1 << W) - 1) : $urandom_range(0, 300),
                  $urandom_range(0, 1));
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
